// File: rtl/pico_ahb_slave_ram.sv
// AHB-Lite word-organised RAM slave with big-endian byte lanes and programmable wait states.
// Define PICO_AHB_SLAVE_ERR_EN to answer oversized/misaligned transfers with a two-cycle ERROR.
module pico_ahb_slave_ram #(
  parameter int ADDR_WDT    = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int AW = ADDR_WDT + 2;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

`ifdef PICO_AHB_SLAVE_ERR_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic {S_IDLE, S_DATA} state_t;
`endif

  logic [31:0]   mem [0:(1<<ADDR_WDT)-1];
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ready, accept, commit;
  logic [1:0]    resp;
  logic [3:0]    wbe;
  logic [31:0]   rword;
  logic          unused_ok;

  // Lane 3 is HWDATA[31:24] and holds byte offset 0; misaligned offsets fall back to the aligned lanes.
  function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      3'b000:  be = 4'b1000 >> off;
      3'b001:  be = off[1] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return w;
  endfunction

  always_comb begin
    ready = 1'b1;
    resp  = 2'b00;
    case (state_q)
      S_DATA: ready = (cnt_q == 4'd0);
`ifdef PICO_AHB_SLAVE_ERR_EN
      S_ERR1: begin ready = 1'b0; resp = 2'b01; end
      S_ERR2: resp = 2'b01;
`endif
      default: ;
    endcase
  end

  assign accept    = HSEL & HREADY & HTRANS[1] & ready;
  assign commit    = (state_q == S_DATA) && (cnt_q == 4'd0) && write_q;
  assign wbe       = lane_en(size_q, addr_q[1:0]);
  assign HREADYOUT = ready;
  assign HRESP     = resp;
  assign HRDATA    = rdata_q;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0], HADDR[31:AW]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    if ((state_q == S_DATA) && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end else if (accept) begin
      addr_d  = HADDR[AW-1:0];
      write_d = HWRITE;
      size_d  = HSIZE;
      state_d = S_DATA;
      cnt_d   = WS_LOAD;
`ifdef PICO_AHB_SLAVE_ERR_EN
      if ((HSIZE > 3'b010) || ((HSIZE == 3'b001) && HADDR[0]) ||
          ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00))) begin
        state_d = S_ERR1;
        cnt_d   = 4'd0;
      end
`endif
    end else begin
`ifdef PICO_AHB_SLAVE_ERR_EN
      if (state_q == S_ERR1) state_d = S_ERR2;
      else
`endif
      state_d = S_IDLE;
    end
  end

  // Read data is captured on the edge that enters the final data-phase cycle, bypassing a
  // write to the same word that commits on that same edge.
  always_comb begin
    rword   = mem[addr_d[AW-1:2]];
    rdata_d = rdata_q;
    if ((state_d == S_DATA) && (cnt_d == 4'd0) && !write_d) begin
      rdata_d = rword;
      if (commit && (addr_q[AW-1:2] == addr_d[AW-1:2])) rdata_d = merge_lanes(rword, HWDATA, wbe);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'b000;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (commit && !HRESET) mem[addr_q[AW-1:2]] <= merge_lanes(mem[addr_q[AW-1:2]], HWDATA, wbe);
  end

endmodule

// File: tb/tb_pico_ahb_slave_ram.sv
// Bench for pico_ahb_slave_ram: one zero-wait and one three-wait instance against a byte-lane memory model.
module tb_pico_ahb_slave_ram;

`ifdef PICO_AHB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  wire         hro0, hro1;
  wire  [1:0]  hresp0, hresp1;
  wire  [31:0] hrd0, hrd1;

  pico_ahb_slave_ram #(.ADDR_WDT(12), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'b000), .HPROT(4'b0011),
    .HWDATA(hwdata[0]), .HREADY(hro0), .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrd0));

  pico_ahb_slave_ram #(.ADDR_WDT(12), .WAIT_STATES(3)) dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'b001), .HPROT(4'b0011),
    .HWDATA(hwdata[1]), .HREADY(hro1), .HREADYOUT(hro1), .HRESP(hresp1), .HRDATA(hrd1));

  int n_chk = 0;
  int n_err = 0;
  bit [31:0] ref_mem [int];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%08h want=%08h", tag, got, exp);
    end
  endtask

  function automatic logic ro(input int d);
    return (d != 0) ? hro1 : hro0;
  endfunction
  function automatic logic [1:0] rsp(input int d);
    return (d != 0) ? hresp1 : hresp0;
  endfunction
  function automatic logic [31:0] rd(input int d);
    return (d != 0) ? hrd1 : hrd0;
  endfunction
  function automatic int ws_of(input int d);
    return (d != 0) ? 3 : 0;
  endfunction

  // 16 KiB wraps: only word index bits [13:2] select storage.
  function automatic int key(input int d, input logic [31:0] a);
    return d * 65536 + int'((a >> 2) & 32'h0000_0FFF);
  endfunction

  function automatic bit is_err(input logic [2:0] sz, input logic [31:0] a);
    bit bad;
    bad = (sz > 3'd2) || ((sz == 3'd1) && a[0]) || ((sz == 3'd2) && (a[1:0] != 2'b00));
    return ERR_EN && bad;
  endfunction

  // Byte at offset b lives in bits [(3-b)*8 +: 8]; the access covers the size-aligned group of bytes.
  function automatic bit [31:0] apply(input bit [31:0] old, input logic [2:0] sz, input int off,
                                      input logic [31:0] wd);
    int nb;
    int base;
    bit [31:0] w;
    w    = old;
    nb   = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    base = off - (off % nb);
    for (int b = base; b < base + nb; b++) w[(3-b)*8 +: 8] = wd[(3-b)*8 +: 8];
    return w;
  endfunction

  task automatic idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0; haddr[d] = 32'd0; hsize[d] = 3'd0;
  endtask

  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rdat, output int waits,
                      output logic [1:0] rw, output logic [1:0] rf);
    hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = wr; haddr[d] = a; hsize[d] = sz;
    @(posedge clk); #1;
    idle(d);
    hwdata[d] = wd;
    waits = 0;
    rw = 2'b00;
    while (!ro(d) && waits < 40) begin
      if (waits == 0) rw = rsp(d);
      @(posedge clk); #1;
      waits++;
    end
    rdat = rd(d);
    rf   = rsp(d);
    @(posedge clk); #1;
  endtask

  task automatic run(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, output logic [31:0] rdat);
    int waits;
    int k;
    logic [1:0] rw, rf;
    xfer(d, wr, a, sz, wd, rdat, waits, rw, rf);
    k = key(d, a);
    if (is_err(sz, a)) begin
      chk("err_waits", waits, 1);
      chk("err_resp1", rw, 2'b01);
      chk("err_resp2", rf, 2'b01);
    end else begin
      chk("waits", waits, ws_of(d));
      chk("wait_resp", rw, 2'b00);
      chk("resp", rf, 2'b00);
      if (wr) ref_mem[k] = apply(ref_mem[k], sz, int'(a[1:0]), wd);
      else    chk("rdata", rdat, ref_mem[k]);
    end
  endtask

  // Write followed by a word read issued during the write's final data-phase cycle.
  task automatic wr_rd(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int n;
    int k;
    hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = 1'b1; haddr[d] = a; hsize[d] = sz;
    @(posedge clk); #1;
    idle(d);
    hwdata[d] = wd;
    n = 0;
    while (!ro(d) && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_wwaits", n, ws_of(d));
    hsel[d] = 1'b1; htrans[d] = 2'b10; hwrite[d] = 1'b0; haddr[d] = a & ~32'd3; hsize[d] = 3'd2;
    @(posedge clk); #1;
    idle(d);
    n = 0;
    while (!ro(d) && n < 40) begin @(posedge clk); #1; n++; end
    chk("b2b_rwaits", n, ws_of(d));
    k = key(d, a);
    ref_mem[k] = apply(ref_mem[k], sz, int'(a[1:0]), wd);
    chk("b2b_rdata", rd(d), ref_mem[k]);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    logic [2:0]  sz;
    int          w, op;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin idle(d); hwdata[d] = 32'd0; end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready0", hro0, 1'b1); chk("rst_resp0", hresp0, 2'b00); chk("rst_rdata0", hrd0, 32'd0);
    chk("rst_ready1", hro1, 1'b1); chk("rst_resp1", hresp1, 2'b00); chk("rst_rdata1", hrd1, 32'd0);

    run(0, 1'b1, 32'h40, 3'd2, 32'hDEADBEEF, r);
    run(0, 1'b0, 32'h40, 3'd2, 32'd0, r);
    chk("word_rd", r, 32'hDEADBEEF);
    run(0, 1'b1, 32'h41, 3'd0, 32'h0011_0000, r);
    run(0, 1'b0, 32'h40, 3'd2, 32'd0, r);
    chk("byte_merge", r, 32'hDE11BEEF);

    // BUSY with HSEL, then NONSEQ without HSEL: neither may touch memory.
    hsel[0] = 1'b1; htrans[0] = 2'b01; hwrite[0] = 1'b1; haddr[0] = 32'h40; hsize[0] = 3'd2;
    hwdata[0] = 32'd0;
    @(posedge clk); #1;
    chk("busy_ready", hro0, 1'b1); chk("busy_resp", hresp0, 2'b00);
    hsel[0] = 1'b0; htrans[0] = 2'b10;
    @(posedge clk); #1;
    chk("nosel_ready", hro0, 1'b1); chk("nosel_resp", hresp0, 2'b00);
    idle(0);
    @(posedge clk); #1;
    run(0, 1'b0, 32'h40, 3'd2, 32'd0, r);
    chk("no_access", r, 32'hDE11BEEF);

    run(0, 1'b1, 32'h42, 3'd2, 32'hFFFFFFFF, r);
    run(0, 1'b0, 32'h40, 3'd2, 32'd0, r);
    wr_rd(0, 32'h80, 3'd2, 32'h12345678);

    run(1, 1'b1, 32'h40, 3'd2, 32'hDEADBEEF, r);
    run(1, 1'b0, 32'h40, 3'd2, 32'd0, r);
    chk("ws3_rd", r, 32'hDEADBEEF);

    // Reset during the second wait state of a write must abort it.
    run(1, 1'b1, 32'hC0, 3'd2, 32'hA5A50F0F, r);
    hsel[1] = 1'b1; htrans[1] = 2'b10; hwrite[1] = 1'b1; haddr[1] = 32'hC0; hsize[1] = 3'd2;
    @(posedge clk); #1;
    idle(1);
    hwdata[1] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("ws2_low", hro1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", hro1, 1'b1); chk("abort_resp", hresp1, 2'b00); chk("abort_rdata", hrd1, 32'd0);
    run(1, 1'b0, 32'hC0, 3'd2, 32'd0, r);
    chk("abort_keep", r, 32'hA5A50F0F);

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) run(d, 1'b1, 32'h100 + 32'(i * 4), 3'd2, $urandom, r);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        w  = $urandom_range(0, 15);
        a  = ($urandom & 32'hFFFF_0000) | (32'h100 + 32'(w * 4));
        op = $urandom_range(0, 3);
        sz = 3'($urandom_range(0, 2));
        if (op == 3) begin
          a[1:0] = (sz == 3'd0) ? 2'($urandom_range(0, 3)) : (sz == 3'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
          wr_rd(d, a, sz, $urandom);
        end else begin
          if ($urandom_range(0, 7) == 0) sz = 3'($urandom_range(3, 7));
          a[1:0] = 2'($urandom_range(0, 3));
          run(d, op != 0, a, sz, $urandom, r);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
